// File: rtl/bcd_scan_display_ctrl.sv
// Multiplexed 7-segment scan controller: one shared BCD decoder, dead time between digits,
// leading-zero blanking, and a shadow register that commits new values only on frame edges.
module bcd_scan_display_ctrl #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned ON_CYCLES   = 1000,
    parameter int unsigned DEAD_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       bcd_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          blank_lz,
    output logic [6:0]                    seg_n,
    output logic                          dp_n,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick,
    output logic                          pending
);

    localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
    localparam int unsigned BcdW   = 4 * NUM_DIGITS;
    localparam int unsigned MaxCnt = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
    localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

    localparam logic [CntW-1:0] OnLast   = CntW'(ON_CYCLES - 1);
    localparam logic [CntW-1:0] DeadLast = CntW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IdxW-1:0] DigLast  = IdxW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {StDead, StOn} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       digit_q, digit_d;
    logic [BcdW-1:0]       act_bcd_q, act_bcd_d, sh_bcd_q, sh_bcd_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic                  tick_q, tick_d;
    logic                  commit;
    logic [NUM_DIGITS-1:0] lz;
    logic [3:0]            cur;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0001100;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        if (!en) begin
            state_d = StDead;
            cnt_d   = '0;
            digit_d = '0;
        end else begin
            unique case (state_q)
                StDead: begin
                    if (DEAD_CYCLES == 0 || cnt_q == DeadLast) begin
                        state_d = StOn;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StOn: begin
                    if (cnt_q == OnLast) begin
                        cnt_d   = '0;
                        digit_d = (digit_q == DigLast) ? '0 : digit_q + IdxW'(1);
                        state_d = (DEAD_CYCLES == 0) ? StOn : StDead;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            endcase
        end
    end

    // tick_q marks the last ON cycle of the last digit, i.e. the frame boundary.
    // Disabling the scan also commits, so a held-off display never keeps stale data.
    always_comb begin
        commit    = !en || tick_q;
        act_bcd_d = act_bcd_q;
        act_dp_d  = act_dp_q;
        sh_bcd_d  = sh_bcd_q;
        sh_dp_d   = sh_dp_q;
        pending_d = pending_q;
        if (load) begin
            sh_bcd_d = bcd_in;
            sh_dp_d  = dp_in;
        end
        if (load && commit) begin
            act_bcd_d = bcd_in;
            act_dp_d  = dp_in;
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end else if (commit && pending_q) begin
            act_bcd_d = sh_bcd_q;
            act_dp_d  = sh_dp_q;
            pending_d = 1'b0;
        end
    end

    // lz[k]: digit k and every digit above it are zero.
    always_comb begin
        lz = '0;
        lz[NUM_DIGITS-1] = (act_bcd_d[BcdW-1 -: 4] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            lz[k] = lz[k+1] && (act_bcd_d[4*k +: 4] == 4'd0);
        end
    end

    always_comb begin
        cur    = act_bcd_d[4*int'(digit_d) +: 4];
        seg_d  = 7'h7F;
        dp_n_d = 1'b1;
        an_n_d = '1;
        tick_d = 1'b0;
        if (state_d == StOn) begin
            an_n_d = ~(NUM_DIGITS'(1) << digit_d);
            seg_d  = (blank_lz && digit_d != '0 && lz[digit_d]) ? 7'h7F : decode(cur);
            dp_n_d = ~act_dp_d[digit_d];
            tick_d = (digit_d == DigLast) && (cnt_d == OnLast);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StDead;
            cnt_q     <= '0;
            digit_q   <= '0;
            act_bcd_q <= '0;
            act_dp_q  <= '0;
            sh_bcd_q  <= '0;
            sh_dp_q   <= '0;
            pending_q <= 1'b0;
            seg_q     <= 7'h7F;
            dp_n_q    <= 1'b1;
            an_n_q    <= '1;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            act_bcd_q <= act_bcd_d;
            act_dp_q  <= act_dp_d;
            sh_bcd_q  <= sh_bcd_d;
            sh_dp_q   <= sh_dp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dp_n_q    <= dp_n_d;
            an_n_q    <= an_n_d;
            tick_q    <= tick_d;
        end
    end

    assign seg_n      = seg_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign digit_idx  = digit_q;
    assign frame_tick = tick_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_bcd_scan_display_ctrl.sv
// Bench for bcd_scan_display_ctrl: a time-position reference model checked every cycle,
// a decode/blanking vector table, hand-written corner sequences and a random phase.
module tb_bcd_scan_display_ctrl;

    localparam int N     = 4;
    localparam int ON    = 4;
    localparam int DEAD  = 2;
    localparam int SLOT  = ON + DEAD;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        rst, en, load, blank_lz;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic [1:0]  digit_idx;
    logic        frame_tick;
    logic        pending;

    bcd_scan_display_ctrl #(
        .NUM_DIGITS (N),
        .ON_CYCLES  (ON),
        .DEAD_CYCLES(DEAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .bcd_in    (bcd_in),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .seg_n     (seg_n),
        .dp_n      (dp_n),
        .an_n      (an_n),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    logic [6:0] dec_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0001100, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                                 7'h7F, 7'h7F};

    // Model: t counts cycles since the scan (re)started; everything derives from t.
    int          t;
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_dp_act, m_dp_sh;
    logic        m_pend, m_blz;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0d: got %h, expected %h", name, t, act, exp);
        end
    endtask

    task automatic model_edge();
        logic c;
        if (rst) begin
            t = 0; m_act = '0; m_sh = '0; m_dp_act = '0; m_dp_sh = '0; m_pend = 1'b0;
        end else begin
            c = !en || (t % FRAME == FRAME - 1);
            if (load) begin
                m_sh = bcd_in; m_dp_sh = dp_in;
            end
            if (load && c) begin
                m_act = bcd_in; m_dp_act = dp_in; m_pend = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end else if (c && m_pend) begin
                m_act = m_sh; m_dp_act = m_dp_sh; m_pend = 1'b0;
            end
            t = en ? t + 1 : 0;
        end
        m_blz = blank_lz;
    endtask

    function automatic int cur_digit();
        return (t % FRAME) / SLOT;
    endfunction

    function automatic logic is_on();
        return ((t % FRAME) % SLOT) >= DEAD;
    endfunction

    task automatic check_all();
        int          d;
        logic [15:0] hi;
        logic [6:0]  e_seg;
        logic [3:0]  e_an;
        logic        e_dp;
        d     = cur_digit();
        hi    = m_act >> (4 * d);
        e_seg = 7'h7F;
        e_an  = 4'hF;
        e_dp  = 1'b1;
        if (is_on()) begin
            e_an  = ~(4'b0001 << d);
            e_seg = (m_blz && d > 0 && hi == 16'd0) ? 7'h7F : dec_tab[hi[3:0]];
            e_dp  = ~m_dp_act[d];
        end
        check("seg_n", 32'(seg_n), 32'(e_seg));
        check("an_n", 32'(an_n), 32'(e_an));
        check("dp_n", 32'(dp_n), 32'(e_dp));
        check("digit_idx", 32'(digit_idx), 32'(d));
        check("frame_tick", 32'(frame_tick), 32'((t % FRAME) == FRAME - 1));
        check("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    typedef struct {
        logic [15:0]     bcd;
        logic [3:0]      dp;
        logic            blz;
        logic [3:0][6:0] seg;
        logic [3:0]      dpn;
    } vec_t;

    vec_t vecs [9];
    int   ticks;

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 1'b0,
                    {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111};
        vecs[1] = '{16'h0070, 4'b0000, 1'b1,
                    {7'h7F, 7'h7F, 7'b0001111, 7'b0000001}, 4'b1111};
        vecs[2] = '{16'h00AB, 4'b0010, 1'b0,
                    {7'b0000001, 7'b0000001, 7'h7F, 7'h7F}, 4'b1101};
        vecs[3] = '{16'h00AB, 4'b0010, 1'b1,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1101};
        vecs[4] = '{16'h9999, 4'b0000, 1'b1,
                    {7'b0001100, 7'b0001100, 7'b0001100, 7'b0001100}, 4'b1111};
        vecs[5] = '{16'h0000, 4'b0001, 1'b1,
                    {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'b1110};
        vecs[6] = '{16'h5678, 4'b1111, 1'b0,
                    {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}, 4'b0000};
        vecs[7] = '{16'h1000, 4'b1001, 1'b1,
                    {7'b1001111, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b0110};
        vecs[8] = '{16'h0CDE, 4'b0000, 1'b1,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};

        rst = 1'b1; en = 1'b0; load = 1'b0; blank_lz = 1'b0; bcd_in = '0; dp_in = '0;
        t = 0; m_act = '0; m_sh = '0; m_dp_act = '0; m_dp_sh = '0; m_pend = 1'b0; m_blz = 1'b0;

        // Reset state
        step(); step();
        check("rst_seg", 32'(seg_n), 32'h7F);
        check("rst_an", 32'(an_n), 32'hF);
        check("rst_dp", 32'(dp_n), 32'h1);
        check("rst_pend", 32'(pending), 32'h0);

        // Free-running scan of zeros, two frames
        rst = 1'b0; en = 1'b1;
        ticks = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (frame_tick) ticks++;
        end
        check("tick_count", 32'(ticks), 32'd2);

        // Mid-frame load stays pending until the boundary
        for (int i = 0; i < 8; i++) step();
        load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0000;
        step();
        load = 1'b0;
        check("pend_mid", 32'(pending), 32'h1);
        for (int i = 0; i < 60 && !((t % FRAME) == 2 && t > FRAME * 3); i++) step();
        check("commit_d0", 32'(seg_n), 32'(7'b1001100));
        check("commit_pend", 32'(pending), 32'h0);

        // Load exactly on the frame_tick cycle bypasses the shadow
        for (int i = 0; i < 2 * FRAME && (t % FRAME) != FRAME - 1; i++) step();
        check("tick_reached", 32'(frame_tick), 32'h1);
        load = 1'b1; bcd_in = 16'h9999;
        step();
        load = 1'b0;
        check("pend_on_tick", 32'(pending), 32'h0);
        for (int i = 0; i < 10 && (t % FRAME) != 2; i++) step();
        check("bypass_d0", 32'(seg_n), 32'(7'b0001100));

        // en dropped mid-slot with a pending value
        step();
        load = 1'b1; bcd_in = 16'h4321;
        step();
        load = 1'b0;
        check("pend_before_en", 32'(pending), 32'h1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("pend_en0", 32'(pending), 32'h0);
        check("an_en0", 32'(an_n), 32'hF);
        en = 1'b1;
        step(); step();
        check("restart_an", 32'(an_n), 32'hE);
        check("restart_seg", 32'(seg_n), 32'(7'b1001111));

        // Reset during an ON period clears the active value
        for (int i = 0; i < 10 && !is_on(); i++) step();
        rst = 1'b1;
        step();
        check("rst2_seg", 32'(seg_n), 32'h7F);
        check("rst2_an", 32'(an_n), 32'hF);
        check("rst2_idx", 32'(digit_idx), 32'h0);
        rst = 1'b0;
        step(); step();
        check("rst2_active", 32'(seg_n), 32'(7'b0000001));

        // Decode and blanking table
        foreach (vecs[v]) begin
            en = 1'b0; load = 1'b1; bcd_in = vecs[v].bcd; dp_in = vecs[v].dp;
            blank_lz = vecs[v].blz;
            step();
            load = 1'b0; en = 1'b1;
            for (int i = 0; i < FRAME; i++) begin
                step();
                if (is_on()) begin
                    check($sformatf("tbl%0d_seg", v), 32'(seg_n), 32'(vecs[v].seg[cur_digit()]));
                    check($sformatf("tbl%0d_dp", v), 32'(dp_n), 32'(vecs[v].dpn[cur_digit()]));
                end
            end
        end

        // Random traffic against the model
        en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
            load = ($urandom_range(0, 14) == 0);
            if (load) begin
                bcd_in = 16'($urandom);
                if ($urandom_range(0, 1) == 0) bcd_in = bcd_in >> (4 * $urandom_range(0, 4));
                dp_in = 4'($urandom);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
